// File: rtl/spart_driver_if.sv
// spart_driver_if: processor-side control lines between spart_driver (master)
// and spart (slave). The 8-bit tri-state data bus stays a plain inout port on
// the driver so that its resolution happens at the pin, not inside the bundle.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_driver.sv
// spart_driver: bus master in front of spart. After reset it programs the
// baud divisor selected by br_cfg, then echoes every received byte back to
// the transmitter. Reprograms the divisor whenever br_cfg changes, but only
// between echoes.
// Optional feature macro: SPART_DRIVER_ECHO_UPPER_EN (echoes 'a'..'z' as
// upper case; rx_byte still reports the raw byte).
module spart_driver #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         br_cfg,
  spart_driver_if.master     bus,
  inout  wire  [7:0]         databus,
  output logic [7:0]         rx_byte,
  output logic               rx_valid,
  output logic [15:0]        echo_cnt
);

  typedef enum logic [2:0] {
    INIT_LO  = 3'd0,
    INIT_HI  = 3'd1,
    IDLE     = 3'd2,
    READ     = 3'd3,
    WAIT_TBR = 3'd4,
    WRITE    = 3'd5
  } state_e;

  localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / (32'd16 * 32'd4800));
  localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / (32'd16 * 32'd9600));
  localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / (32'd16 * 32'd19200));
  localparam logic [15:0] DIV_38400 = 16'(CLK_FREQ / (32'd16 * 32'd38400));

  state_e      state_r;
  state_e      state_nx_s;
  logic        armed_r;      // low only in the first cycle after reset release
  logic [1:0]  cfg_q;        // registered br_cfg
  logic [1:0]  prog_cfg_r;   // configuration whose divisor is (being) programmed
  logic [7:0]  held_r;       // byte awaiting echo
  logic        iocs_r;
  logic        iorw_r;
  logic        oe_r;
  logic [1:0]  ioaddr_r;
  logic        cfg_pend_s;
  logic [15:0] div_s;
  logic [7:0]  wdata_s;

  function automatic logic [15:0] div_for(input logic [1:0] sel);
    logic [15:0] d;
    case (sel)
      2'b00:   d = DIV_4800;
      2'b01:   d = DIV_9600;
      2'b10:   d = DIV_19200;
      2'b11:   d = DIV_38400;
      default: d = DIV_9600;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] echo_xform(input logic [7:0] b);
`ifdef SPART_DRIVER_ECHO_UPPER_EN
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      return b - 8'h20;
    end else begin
      return b;
    end
`else
    return b;
`endif
  endfunction

  // Bus control decode per state: {oe, iocs, iorw, ioaddr}. iorw = 1 never drives.
  function automatic logic [4:0] bus_ctl(input state_e s);
    logic [4:0] c;
    case (s)
      INIT_LO: c = {1'b1, 1'b1, 1'b0, 2'b10};
      INIT_HI: c = {1'b1, 1'b1, 1'b0, 2'b11};
      READ:    c = {1'b0, 1'b1, 1'b1, 2'b00};
      WRITE:   c = {1'b1, 1'b1, 1'b0, 2'b00};
      default: c = {1'b0, 1'b0, 1'b1, 2'b00};
    endcase
    return c;
  endfunction

  // Pending reprogram flag and the write data for the current state.
  always_comb begin
    cfg_pend_s = (cfg_q != prog_cfg_r);
    div_s      = div_for(prog_cfg_r);
    case (state_r)
      INIT_LO: wdata_s = div_s[7:0];
      INIT_HI: wdata_s = div_s[15:8];
      default: wdata_s = echo_xform(held_r);
    endcase
  end

  // Next-state logic; the first post-reset cycle holds in INIT_LO to arm outputs.
  always_comb begin
    state_nx_s = IDLE;
    if (!armed_r) begin
      state_nx_s = INIT_LO;
    end else begin
      case (state_r)
        INIT_LO:  state_nx_s = INIT_HI;
        INIT_HI:  state_nx_s = IDLE;
        IDLE: begin
          if (cfg_pend_s) begin
            state_nx_s = INIT_LO;
          end else if (bus.rda) begin
            state_nx_s = READ;
          end else begin
            state_nx_s = IDLE;
          end
        end
        READ:     state_nx_s = WAIT_TBR;
        WAIT_TBR: state_nx_s = bus.tbr ? WRITE : WAIT_TBR;
        WRITE:    state_nx_s = IDLE;
        default:  state_nx_s = IDLE;
      endcase
    end
  end

  // FSM state, registered bus controls, byte capture and echo counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= INIT_LO;
      armed_r    <= 1'b0;
      cfg_q      <= 2'b00;
      prog_cfg_r <= 2'b00;
      held_r     <= 8'h00;
      oe_r       <= 1'b0;
      iocs_r     <= 1'b0;
      iorw_r     <= 1'b1;
      ioaddr_r   <= 2'b00;
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      echo_cnt   <= 16'h0000;
    end else begin
      armed_r <= 1'b1;
      state_r <= state_nx_s;
      cfg_q   <= br_cfg;
      {oe_r, iocs_r, iorw_r, ioaddr_r} <= bus_ctl(state_nx_s);
      rx_valid <= 1'b0;
      if (!armed_r) begin
        prog_cfg_r <= br_cfg;
      end else if ((state_r == IDLE) && (state_nx_s == INIT_LO)) begin
        prog_cfg_r <= cfg_q;
      end
      if (armed_r && (state_r == READ)) begin
        held_r   <= databus;
        rx_byte  <= databus;
        rx_valid <= 1'b1;
      end
      if (armed_r && (state_r == WRITE)) begin
        echo_cnt <= echo_cnt + 16'd1;
      end
    end
  end

  assign bus.iocs   = iocs_r;
  assign bus.iorw   = iorw_r;
  assign bus.ioaddr = ioaddr_r;
  assign databus    = oe_r ? wdata_s : 8'hzz;

endmodule

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus-master stage that sits directly upstream of spart on its iocs/iorw/ioaddr/databus processor interface.
- After reset, programs the spart baud divisor from br_cfg.
- Then loops: polls rda, reads each received byte, waits for tbr, and writes the byte back for transmission (echo).
- Exposes the received byte and an echo count to the top level.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- Divisor table: DIV(rate) = CLK_FREQ/(16*rate), integer floor, 16 bits.
- At the default CLK_FREQ: 4800 -> 0x0516, 9600 -> 0x028B, 19200 -> 0x0145, 38400 -> 0x00A2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- br_cfg  in  2  baud select: 00 = 4800, 01 = 9600, 10 = 19200, 11 = 38400.
- rda  in  1  spart receive-data-available.
- tbr  in  1  spart transmit-buffer-ready.
- iocs  out  1  spart chip select, active high.
- iorw  out  1  1 = read from spart, 0 = write to spart.
- ioaddr  out  2  00 = tx/rx buffer, 01 = status, 10 = divisor low, 11 = divisor high.
- databus  inout  8  shared data bus; driven only during write cycles, otherwise Z.
- rx_byte  out  8  last byte read from spart.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- echo_cnt  out  16  count of completed echo writes; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst low, async): state = INIT_LO, iocs = 0, iorw = 1, ioaddr = 00, databus = Z, rx_byte = 0x00, rx_valid = 0, echo_cnt = 0, held byte = 0x00.
- br_cfg is registered; that registered value (cfg_q) selects the divisor.
- All bus outputs decode from the state register only (Moore). Each bus access lasts exactly one clk cycle.
- States and transitions:
  - INIT_LO: iocs = 1, iorw = 0, ioaddr = 10, databus = DIV[7:0]. Always -> INIT_HI.
  - INIT_HI: iocs = 1, iorw = 0, ioaddr = 11, databus = DIV[15:8]. Always -> IDLE.
  - IDLE: iocs = 0, databus = Z.
    - cfg change pending -> INIT_LO (takes priority over rda).
    - else rda = 1 -> READ.
    - else stay in IDLE.
  - READ: iocs = 1, iorw = 1, ioaddr = 00, databus = Z.
    - At the closing edge: capture databus into the held byte and rx_byte; rx_valid = 1 in the following cycle only.
    - Always -> WAIT_TBR.
  - WAIT_TBR: iocs = 0. tbr = 1 -> WRITE; else stay.
  - WRITE: iocs = 1, iorw = 0, ioaddr = 00, databus = held byte.
    - At the closing edge: echo_cnt += 1.
    - Always -> IDLE.
- Latency:
  - First divisor write occurs in the first cycle after reset release; IDLE is reached on cycle 3.
  - rda seen in IDLE -> READ on the next cycle.
  - Minimum rda-to-WRITE is 3 cycles when tbr is already 1.
- Config change: a difference between the current cfg_q and the divisor last programmed sets a pending flag.
  - The flag is acted on only in IDLE.
  - A byte in flight (READ / WAIT_TBR / WRITE) is echoed first with the old divisor.
- Backpressure: while in WAIT_TBR, rda is ignored. Further bytes remain in spart; they are not dropped by this block.
- rda and tbr asserted together in IDLE: only the read proceeds; tbr is considered in WAIT_TBR.
- Reset mid-operation: immediate return to reset values. A held byte is discarded and reprogramming restarts at INIT_LO.
- Bus contention rule: databus is never driven in a cycle where iorw = 1. Any state not listed decodes to IDLE outputs and transitions to IDLE.

Optional Feature:
- Macro: SPART_DRIVER_ECHO_UPPER_EN.
- Defined: in WRITE, a held byte in 0x61..0x7A ('a'..'z') is driven minus 0x20. All other bytes pass unchanged. rx_byte always shows the raw byte.
- Undefined: WRITE drives the held byte unmodified.

Test Plan:
- Reset release with br_cfg = 01 -> cycle 1: ioaddr = 10, databus = 0x8B, iocs = 1, iorw = 0. Cycle 2: ioaddr = 11, databus = 0x02. Then iocs = 0.
- In IDLE, pulse rda = 1 while the model drives 0x41 on read, tbr = 1 -> one READ cycle, rx_valid pulse with rx_byte = 0x41, WRITE of 0x41 to ioaddr 00 three cycles after rda, echo_cnt = 1.
- Read 0x5A with tbr held 0 for 20 cycles -> iocs = 0 throughout the wait. WRITE of 0x5A occurs the cycle after tbr rises; rda pulses during the wait cause no extra READ.
- Change br_cfg from 01 to 11 while in WAIT_TBR -> the pending echo completes first, then INIT_LO/INIT_HI write 0xA2 / 0x00, then IDLE.
- Preload echo_cnt path with 65535 echoes (or force) -> next WRITE gives echo_cnt = 0x0000. Assert rst low during WRITE -> iocs = 0 and databus = Z immediately, INIT_LO after release.
- With SPART_DRIVER_ECHO_UPPER_EN: read 0x61 -> WRITE 0x41. Read 0x7B -> WRITE 0x7B. Without the macro: read 0x61 -> WRITE 0x61.
